// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU selects,
// opcode classes and the DP command to ALUControl decode.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned INSTR_W = 20;

    // FSM state encodings
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Op field encodings
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Data-processing cmd field (Funct[4:1]) values
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Map a DP cmd to ALUControl; unsupported commands fall back to ADD
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] sel;
        case (cmd)
            CMD_ADD: sel = ALU_ADD;
            CMD_SUB: sel = ALU_SUB;
            CMD_AND: sel = ALU_AND;
            CMD_ORR: sel = ALU_ORR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// ARM condition-code evaluation: Cond and stored {N,Z,C,V} -> CondEx.
// Code 1111 never executes.
module mc_condcheck
    import mc_pkg::*;
(
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Standard ARM condition table
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = ~(n ^ v);
            4'b1011: cond_ex = n ^ v;
            4'b1100: cond_ex = ~z & ~(n ^ v);
            4'b1101: cond_ex = z | (n ^ v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM controller: Moore FSM driving datapath enables/selects,
// plus the stored condition flags and the registered CondEx.
// Optional feature: define MC_BL_EN to support BL (writes PC+4 to R14, adds Link port).
module mc_controller
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [FLAG_W-1:0]  ALUFlags,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUControl,
    output logic [STATE_W-1:0] State
`ifdef MC_BL_EN
    ,
    output logic               Link
`endif
);

    logic [3:0]         cond;
    logic [1:0]         op;
    logic [5:0]         funct;
    logic [3:0]         rd;
    logic               unused_rn;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [FLAG_W-1:0]  flags;
    logic               cond_ex;
    logic               condex_reg;
    logic               in_execute;
    logic               nz_we;
    logic               cv_we;
    logic [1:0]         imm_dec;
    logic [1:0]         regsrc_dec;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    mc_condcheck u_condcheck (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // Flag write enables: S bit set and instruction actually executing
    assign in_execute = (state == S_EXECUTER) || (state == S_EXECUTEI);
    assign nz_we      = in_execute && funct[0] && condex_reg;
    assign cv_we      = nz_we && ((funct[4:1] == CMD_ADD) || (funct[4:1] == CMD_SUB));

    // Instruction-class decode for the extend unit and register-read muxes
    assign imm_dec    = (op == OP_MEM) ? 2'b01 : ((op == OP_BR) ? 2'b10 : 2'b00);
    assign regsrc_dec = {(op == OP_MEM) && !funct[0], op == OP_BR};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Stored flags and CondEx captured in DECODE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags      <= '0;
            condex_reg <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                condex_reg <= cond_ex;
            end
            if (nz_we) begin
                flags[3:2] <= ALUFlags[3:2];
            end
            if (cv_we) begin
                flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        next_state = S_FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
`ifdef MC_BL_EN
        Link       = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = condex_reg;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                MemWrite   = condex_reg;
                next_state = S_FETCH;
            end
            S_EXECUTER: begin
                ALUControl = alu_decode(funct[4:1]);
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct[4:1]);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = condex_reg;
                PCWrite    = (rd == 4'b1111) && condex_reg;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex_reg;
`ifdef MC_BL_EN
                if (funct[4]) begin
                    RegWrite = condex_reg;
                    Link     = 1'b1;
                end
`endif
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Extend and register-source selects follow the latched instruction
        if ((state >= S_DECODE) && (state <= S_BRANCH)) begin
            ImmSrc = imm_dec;
            RegSrc = regsrc_dec;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
// Define MC_BL_EN for both bench and RTL to exercise the BL scenario.
module tb_mc_controller;

    logic        clk;
    logic        reset_n;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  State;
`ifdef MC_BL_EN
    logic        Link;
`endif

    int total;
    int bad;

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
`ifdef MC_BL_EN
        ,
        .Link       (Link)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        #3;
        total++;
        if (State !== 4'd0) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", State);
        end
        total++;
        if (dut.flags !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", dut.flags);
        end
        total++;
        if (dut.condex_reg !== 1'b0) begin
            bad++; $display("FAIL reset_condex got=%b exp=0", dut.condex_reg);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if ({IRWrite, PCWrite, MemWrite, RegWrite} !== 4'b1100) begin
            bad++; $display("FAIL reset_fetch_en got=%b exp=1100", {IRWrite, PCWrite, MemWrite, RegWrite});
        end
    endtask

    task automatic test_add_imm();
        logic [3:0] exp_st [5];
        exp_st   = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        Instr    = {4'hE, 2'b00, 6'b101000, 4'h1, 4'h2};
        ALUFlags = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (State !== exp_st[i]) begin
                bad++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, State, exp_st[i]);
            end
            total++;
            if (RegWrite !== 1'(i == 3)) begin
                bad++; $display("FAIL add_regwrite[%0d] got=%b exp=%b", i, RegWrite, 1'(i == 3));
            end
            if (i == 2) begin
                total++;
                if ({ALUControl, ALUSrcA, ALUSrcB} !== 6'b00_00_01) begin
                    bad++; $display("FAIL add_exec_sel got=%b exp=000001", {ALUControl, ALUSrcA, ALUSrcB});
                end
            end
            if (i < 4) tick();
        end
        total++;
        if (dut.flags !== 4'b0000) begin
            bad++; $display("FAIL add_noS_flags got=%b exp=0000", dut.flags);
        end
    endtask

    task automatic test_dp_to_pc();
        Instr    = {4'hE, 2'b00, 6'b101000, 4'h0, 4'hF};
        ALUFlags = 4'h0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (PCWrite !== 1'(i == 0 || i == 3 || i == 4)) begin
                bad++; $display("FAIL pcdst_pcwrite[%0d] got=%b exp=%b", i, PCWrite, 1'(i == 0 || i == 3 || i == 4));
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_cond_never();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        Instr  = {4'hF, 2'b00, 6'b101000, 4'h1, 4'hF};
        for (int i = 0; i < 5; i++) begin
            total++;
            if (State !== exp_st[i]) begin
                bad++; $display("FAIL nv_state[%0d] got=%0d exp=%0d", i, State, exp_st[i]);
            end
            if (i == 3) begin
                total++;
                if ({RegWrite, PCWrite} !== 2'b00) begin
                    bad++; $display("FAIL nv_writes got=%b exp=00", {RegWrite, PCWrite});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_ldr();
        logic [3:0] exp_st [6];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        Instr  = {4'hE, 2'b01, 6'b011001, 4'h1, 4'h2};
        for (int i = 0; i < 6; i++) begin
            total++;
            if (State !== exp_st[i]) begin
                bad++; $display("FAIL ldr_state[%0d] got=%0d exp=%0d", i, State, exp_st[i]);
            end
            total++;
            if (RegWrite !== 1'(i == 4)) begin
                bad++; $display("FAIL ldr_regwrite[%0d] got=%b exp=%b", i, RegWrite, 1'(i == 4));
            end
            if (i == 2) begin
                total++;
                if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b00_01_01) begin
                    bad++; $display("FAIL ldr_adr_sel got=%b exp=000101", {ALUSrcA, ALUSrcB, ImmSrc});
                end
            end
            if (i == 3) begin
                total++;
                if (AdrSrc !== 1'b1) begin
                    bad++; $display("FAIL ldr_adrsrc got=%b exp=1", AdrSrc);
                end
            end
            if (i == 4) begin
                total++;
                if (ResultSrc !== 2'b01) begin
                    bad++; $display("FAIL ldr_resultsrc got=%b exp=01", ResultSrc);
                end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_str();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        Instr  = {4'hE, 2'b01, 6'b011000, 4'h1, 4'h2};
        for (int i = 0; i < 5; i++) begin
            total++;
            if (State !== exp_st[i]) begin
                bad++; $display("FAIL str_state[%0d] got=%0d exp=%0d", i, State, exp_st[i]);
            end
            total++;
            if (MemWrite !== 1'(i == 3)) begin
                bad++; $display("FAIL str_memwrite[%0d] got=%b exp=%b", i, MemWrite, 1'(i == 3));
            end
            if (i == 1) begin
                total++;
                if (RegSrc !== 2'b10) begin
                    bad++; $display("FAIL str_regsrc got=%b exp=10", RegSrc);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_subs_beq();
        logic [3:0] exp_st [5];
        exp_st   = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        Instr    = {4'hE, 2'b00, 6'b000101, 4'h1, 4'h2};
        ALUFlags = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (State !== exp_st[i]) begin
                bad++; $display("FAIL subs_state[%0d] got=%0d exp=%0d", i, State, exp_st[i]);
            end
            if (i == 2) begin
                total++;
                if ({ALUControl, ALUSrcB} !== 4'b01_00) begin
                    bad++; $display("FAIL subs_exec_sel got=%b exp=0100", {ALUControl, ALUSrcB});
                end
            end
            if (i < 4) tick();
        end
        total++;
        if (dut.flags !== 4'b0100) begin
            bad++; $display("FAIL subs_flags got=%b exp=0100", dut.flags);
        end
        Instr    = {4'h0, 2'b10, 6'b100000, 4'h0, 4'h0};
        ALUFlags = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (State !== 4'(i == 3 ? 0 : (i == 2 ? 9 : i))) begin
                bad++; $display("FAIL beq_state[%0d] got=%0d", i, State);
            end
            if (i == 2) begin
                total++;
                if ({PCWrite, ImmSrc, RegSrc} !== 5'b1_10_01) begin
                    bad++; $display("FAIL beq_branch got=%b exp=11001", {PCWrite, ImmSrc, RegSrc});
                end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_bne();
        Instr = {4'h1, 2'b10, 6'b100000, 4'h0, 4'h0};
        tick();
        tick();
        total++;
        if ({State, PCWrite, RegWrite} !== 6'b1001_00) begin
            bad++; $display("FAIL bne_branch got=%b exp=100100", {State, PCWrite, RegWrite});
        end
        tick();
    endtask

    task automatic test_undef();
        Instr = {4'hE, 2'b11, 6'b000000, 4'h0, 4'h0};
        tick();
        total++;
        if ({State, PCWrite, MemWrite, RegWrite, IRWrite} !== 8'b0001_0000) begin
            bad++; $display("FAIL undef_decode got=%b exp=00010000", {State, PCWrite, MemWrite, RegWrite, IRWrite});
        end
        tick();
        total++;
        if (State !== 4'd0) begin
            bad++; $display("FAIL undef_return got=%0d exp=0", State);
        end
    endtask

    task automatic test_reset_mid();
        Instr    = {4'hE, 2'b01, 6'b011000, 4'h1, 4'h2};
        ALUFlags = 4'h0;
        tick();
        tick();
        tick();
        total++;
        if ({State, MemWrite} !== 5'b0101_1) begin
            bad++; $display("FAIL rmid_pre got=%b exp=01011", {State, MemWrite});
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({State, MemWrite} !== 5'b0000_0) begin
            bad++; $display("FAIL rmid_abort got=%b exp=00000", {State, MemWrite});
        end
        total++;
        if (dut.flags !== 4'b0000) begin
            bad++; $display("FAIL rmid_flags got=%b exp=0000", dut.flags);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef MC_BL_EN
    task automatic test_bl();
        Instr = {4'hE, 2'b10, 6'b110000, 4'h0, 4'h0};
        tick();
        tick();
        total++;
        if ({State, RegWrite, PCWrite, Link, RegSrc[0]} !== 8'b1001_1111) begin
            bad++; $display("FAIL bl_branch got=%b exp=10011111", {State, RegWrite, PCWrite, Link, RegSrc[0]});
        end
        tick();
        total++;
        if ({State, Link} !== 5'b0000_0) begin
            bad++; $display("FAIL bl_return got=%b exp=00000", {State, Link});
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add_imm();
        test_dp_to_pc();
        test_cond_never();
        test_ldr();
        test_str();
        test_subs_beq();
        test_bne();
        test_undef();
        test_reset_mid();
`ifdef MC_BL_EN
        test_bl();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all widths SHALL be fixed.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 Instr  in  20  instruction bits [31:12] from the instruction register: Cond, Op, Funct, Rd.
REQ-005 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-006 PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables.
REQ-007 AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  2 each  datapath mux and ALU selects.
REQ-009 State  out  4  current FSM state, for debug.

Function
REQ-010 The FSM SHALL have these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-011 FETCH SHALL assert IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, and PCWrite=1 unconditionally; next state is DECODE.
REQ-012 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10 so that R15 reads as PC+8, and SHALL register CondEx from Cond and the stored flags.
REQ-013 DECODE transitions:
- Op=01 goes to MEMADR.
- Op=00 with Funct[5]=1 goes to EXECUTEI.
- Op=00 with Funct[5]=0 goes to EXECUTER.
- Op=10 goes to BRANCH.
- Op=11 goes to FETCH with no writes.
REQ-014 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ALUControl=00; next state is MEMRD if Funct[0]=1, otherwise MEMWR.
REQ-015 MEMRD SHALL drive AdrSrc=1 and go to MEMWB; MEMWB SHALL drive ResultSrc=01 with RegWrite=CondExReg and go to FETCH.
REQ-016 MEMWR SHALL drive AdrSrc=1 with MemWrite=CondExReg and go to FETCH.
REQ-017 EXECUTER drives ALUSrcB=00 and EXECUTEI drives ALUSrcB=01, both with ALUSrcA=00. Both SHALL decode ALUControl from Funct[4:1]: 0100=00 ADD, 0010=01 SUB, 0000=10 AND, 1100=11 ORR. Both go to ALUWB.
REQ-018 ALUWB SHALL drive ResultSrc=00 with RegWrite=CondExReg; if Rd=1111, PCWrite=CondExReg; next state is FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=CondExReg; next state is FETCH.
REQ-020 Flags register: in EXECUTER/EXECUTEI with S=1 and CondExReg=1, N,Z SHALL update at the clock edge; C,V SHALL update only for ADD/SUB.
REQ-021 Condition codes 0000-1110 SHALL follow standard ARM semantics; code 1111 SHALL evaluate CondEx=0.
REQ-022 ImmSrc SHALL be 00 for DP, 01 for memory, 10 for branch. RegSrc[0]=1 only for branch; RegSrc[1]=1 only for STR.
REQ-023 Latency in cycles: B=3, DP=4, STR=4, LDR=5, undefined=2.
REQ-024 Outputs not listed for a state SHALL be 0; no output is x in any state.
REQ-025 An illegal State encoding SHALL drive all enables to 0 and transition to FETCH.

Reset
REQ-026 reset_n=0 SHALL force, asynchronously, State=FETCH, Flags=0000, CondExReg=0.
REQ-027 After deassertion, the first rising edge SHALL execute FETCH.
REQ-028 Reset mid-instruction SHALL abort the instruction with no further writes.

Configuration
REQ-029 With MC_BL_EN defined, Op=10 with Funct[4]=1 SHALL go DECODE -> BRANCH and also write PC+4 to R14. For this: RegWrite=CondExReg and RegSrc[0]=1, with a Link output (1 bit) high in BRANCH.
REQ-030 Without MC_BL_EN, Funct[4] SHALL be ignored, no R14 write SHALL occur, and the Link port SHALL be absent.

Structure
REQ-031 Package mc_pkg SHALL hold the state enum, the ALUControl encodings and the Op encodings.
REQ-032 Condition evaluation SHALL be a sub-module, mc_condcheck (combinational, Cond/Flags -> CondEx); the FSM and registers stay in mc_controller.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then Instr=E28xx (ADD imm): States 0,1,7,8,0; RegWrite=1 only in ALUWB; ALUControl=00 in EXECUTEI.
- LDR (Op=01, L=1): States 0,1,2,3,4, with RegWrite=1 and ResultSrc=01 in state 4. STR: MemWrite=1 only in state 5.
- SUBS with equal operands (Z=1 from the ALU), then BEQ (cond 0000): PCWrite=1 in BRANCH. The same with BNE: PCWrite=0.
- Op=11: two cycles, FETCH -> DECODE -> FETCH, with zero writes.
- reset_n pulled low during MEMWR: State=0 immediately, MemWrite=0, Flags=0.
- With MC_BL_EN defined, BL: RegWrite=1 and PCWrite=1 in BRANCH.
